// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-master SRAM data-port arbiter.
package sram_arb_pkg;

    typedef enum logic {
        MST_CORE = 1'b0,
        MST_HOST = 1'b1
    } mst_id_e;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        err;
    } obi_rsp_t;

    localparam logic [31:0] SRAM_ERR_RDATA = 32'hDEAD_BEEF;

    function automatic logic addr_in_window(input logic [31:0] addr,
                                            input logic [31:0] base,
                                            input logic [31:0] limit);
        return (addr >= base) && (addr < limit);
    endfunction

endpackage

// File: rtl/sram_arb_rr2.sv
// Two-way round-robin selector; the pointer remembers the last master served.
module sram_arb_rr2
    import sram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       handshake,
    output mst_id_e    sel
);

    mst_id_e last_q;

    always_comb begin
        sel = MST_CORE;
        case (req)
            2'b10:   sel = MST_HOST;
            2'b11:   sel = (last_q == MST_HOST) ? MST_CORE : MST_HOST;
            default: sel = MST_CORE;
        endcase
    end

    // Resetting to the host makes the core win the first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= MST_HOST;
        end else if (handshake) begin
            last_q <= sel;
        end
    end

endmodule

// File: rtl/sram_d_arbiter.sv
// Round-robin merge of core LSU (m0) and host bridge (m1) onto the SRAM data port.
// Define SRAM_ARB_ADDR_CHECK_EN to reject out-of-window addresses with an error response.
module sram_d_arbiter
    import sram_arb_pkg::*;
#(
    parameter logic [31:0] SRAM_BASE_ADDR = 32'h8000_0000,
    parameter logic [31:0] SRAM_END_ADDR  = 32'h8000_C000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    output logic        m0_gnt_o,
    input  logic [31:0] m0_addr_i,
    input  logic        m0_we_i,
    input  logic [3:0]  m0_be_i,
    input  logic [31:0] m0_wdata_i,
    output logic        m0_rvalid_o,
    output logic [31:0] m0_rdata_o,
    output logic        m0_err_o,
    input  logic        m1_req_i,
    output logic        m1_gnt_o,
    input  logic [31:0] m1_addr_i,
    input  logic        m1_we_i,
    input  logic [3:0]  m1_be_i,
    input  logic [31:0] m1_wdata_i,
    output logic        m1_rvalid_o,
    output logic [31:0] m1_rdata_o,
    output logic        m1_err_o,
    output logic        sram_d_req_o,
    input  logic        sram_d_gnt_i,
    output logic [31:0] sram_d_addr_o,
    output logic        sram_d_we_o,
    output logic [3:0]  sram_d_be_o,
    output logic [31:0] sram_d_wdata_o,
    input  logic        sram_d_rvalid_i,
    input  logic [31:0] sram_d_rdata_i,
    output logic        illegal_o
);

`ifdef SRAM_ARB_ADDR_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    obi_req_t m0_bus, m1_bus, sel_bus;
    obi_rsp_t m0_rsp, m1_rsp;
    mst_id_e  sel, owner_q;
    logic     legal, sel_gnt, handshake;
    logic     fwd_q, err_q;
    logic     rsp_valid;
    logic [31:0] rsp_data;

    sram_arb_rr2 u_rr2 (
        .clk       (clk_i),
        .rst       (rst_i),
        .req       ({m1_req_i, m0_req_i}),
        .handshake (handshake),
        .sel       (sel)
    );

    always_comb begin
        m0_bus  = '{req: m0_req_i, addr: m0_addr_i, we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
        m1_bus  = '{req: m1_req_i, addr: m1_addr_i, we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};
        sel_bus = (sel == MST_HOST) ? m1_bus : m0_bus;

        legal     = ~CHECK_EN | addr_in_window(sel_bus.addr, SRAM_BASE_ADDR, SRAM_END_ADDR);
        // Illegal requests are accepted locally so the master never stalls on them.
        sel_gnt   = sel_bus.req & (legal ? sram_d_gnt_i : 1'b1);
        handshake = sel_gnt;

        sram_d_req_o   = sel_bus.req & legal;
        sram_d_addr_o  = sel_bus.req ? sel_bus.addr  : 32'h0;
        sram_d_we_o    = sel_bus.req ? sel_bus.we    : 1'b0;
        sram_d_be_o    = sel_bus.req ? sel_bus.be    : 4'h0;
        sram_d_wdata_o = sel_bus.req ? sel_bus.wdata : 32'h0;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fwd_q   <= 1'b0;
            err_q   <= 1'b0;
            owner_q <= MST_CORE;
        end else begin
            fwd_q <= handshake & legal;
            err_q <= handshake & ~legal;
            if (handshake) begin
                owner_q <= sel;
            end
        end
    end

    always_comb begin
        rsp_valid = (sram_d_rvalid_i & fwd_q) | err_q;
        rsp_data  = err_q ? SRAM_ERR_RDATA : sram_d_rdata_i;

        m0_rsp.gnt    = (sel == MST_CORE) & sel_gnt;
        m0_rsp.rvalid = rsp_valid & (owner_q == MST_CORE);
        m0_rsp.rdata  = m0_rsp.rvalid ? rsp_data : 32'h0;
        m0_rsp.err    = err_q & (owner_q == MST_CORE);

        m1_rsp.gnt    = (sel == MST_HOST) & sel_gnt;
        m1_rsp.rvalid = rsp_valid & (owner_q == MST_HOST);
        m1_rsp.rdata  = m1_rsp.rvalid ? rsp_data : 32'h0;
        m1_rsp.err    = err_q & (owner_q == MST_HOST);
    end

    assign m0_gnt_o    = m0_rsp.gnt;
    assign m0_rvalid_o = m0_rsp.rvalid;
    assign m0_rdata_o  = m0_rsp.rdata;
    assign m0_err_o    = m0_rsp.err;
    assign m1_gnt_o    = m1_rsp.gnt;
    assign m1_rvalid_o = m1_rsp.rvalid;
    assign m1_rdata_o  = m1_rsp.rdata;
    assign m1_err_o    = m1_rsp.err;
    assign illegal_o   = err_q;

endmodule
